// File: rtl/decode_wb_scoreboard_if.sv
// Decode/write-back bundle: decode request and operand results, write-back retire port, scoreboard error.
interface decode_wb_scoreboard_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IDX_W  = 4
);
    logic              d_valid;
    logic [3:0]        d_icode;
    logic [IDX_W-1:0]  d_rA;
    logic [IDX_W-1:0]  d_rB;
    logic [IDX_W-1:0]  d_srcA;
    logic [IDX_W-1:0]  d_srcB;
    logic [IDX_W-1:0]  d_dstE;
    logic [IDX_W-1:0]  d_dstM;
    logic [DATA_W-1:0] d_valA;
    logic [DATA_W-1:0] d_valB;
    logic              d_stall;
    logic              w_en;
    logic              w_cnd;
    logic [IDX_W-1:0]  w_dstE;
    logic [IDX_W-1:0]  w_dstM;
    logic [DATA_W-1:0] w_valE;
    logic [DATA_W-1:0] w_valM;
    logic              sb_err;

    modport slave (
        input  d_valid, d_icode, d_rA, d_rB,
        input  w_en, w_cnd, w_dstE, w_dstM, w_valE, w_valM,
        output d_srcA, d_srcB, d_dstE, d_dstM, d_valA, d_valB, d_stall, sb_err
    );

    modport master (
        output d_valid, d_icode, d_rA, d_rB,
        output w_en, w_cnd, w_dstE, w_dstM, w_valE, w_valM,
        input  d_srcA, d_srcB, d_dstE, d_dstM, d_valA, d_valB, d_stall, sb_err
    );
endinterface

// File: rtl/decode_wb_scoreboard.sv
// Y86 decode/write-back stage: register file with write-first bypass and a
// per-register pending-write counter scoreboard that stalls decode on hazards.
module decode_wb_scoreboard #(
    parameter int unsigned          DATA_W  = 32,
    parameter int unsigned          IDX_W   = 4,
    parameter int unsigned          NREGS   = 15,
    parameter int unsigned          RSP_IDX = 4,
    parameter logic [DATA_W-1:0]    SP_INIT = DATA_W'(32'h0000_0200),
    parameter int unsigned          CNT_W   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    decode_wb_scoreboard_if.slave   bus
);

    localparam logic [IDX_W-1:0] RNONE = '1;
    localparam logic [IDX_W-1:0] RSP   = IDX_W'(RSP_IDX);
    localparam int unsigned      EW    = CNT_W + 2;
    localparam logic [EW-1:0]    CMAX  = EW'((1 << CNT_W) - 1);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [CNT_W-1:0]  cnt_q  [NREGS];
    logic [CNT_W-1:0]  cnt_d  [NREGS];
    logic [EW-1:0]     eff    [NREGS];
    logic [1:0]        res    [NREGS];
    logic              err_q, err_d;
    logic [IDX_W-1:0]  src_a, src_b, dst_e, dst_m;
    logic              stall;

    always_comb begin
        src_a = RNONE;
        src_b = RNONE;
        dst_e = RNONE;
        dst_m = RNONE;
        case (bus.d_icode)
            4'h2: begin src_a = bus.d_rA; dst_e = bus.d_rB; end
            4'h3: begin dst_e = bus.d_rB; end
            4'h4: begin src_a = bus.d_rA; src_b = bus.d_rB; end
            4'h5: begin src_b = bus.d_rB; dst_m = bus.d_rA; end
            4'h6: begin src_a = bus.d_rA; src_b = bus.d_rB; dst_e = bus.d_rB; end
            4'h8: begin src_b = RSP; dst_e = RSP; end
            4'h9: begin src_a = RSP; src_b = RSP; dst_e = RSP; end
            4'hA: begin src_a = bus.d_rA; src_b = RSP; dst_e = RSP; end
            4'hB: begin src_a = RSP; src_b = RSP; dst_e = RSP; dst_m = bus.d_rA; end
            default: ;
        endcase
    end

    // regs_d is the write-first view, so it doubles as the bypassed read source.
    always_comb begin
        for (int unsigned r = 0; r < NREGS; r++) begin
            regs_d[r] = regs_q[r];
            if (bus.w_en && bus.w_cnd && bus.w_dstE == IDX_W'(r))
                regs_d[r] = bus.w_valE;
            if (bus.w_en && bus.w_dstM == IDX_W'(r))
                regs_d[r] = bus.w_valM;
        end
    end

    always_comb begin
        err_d = err_q;
        stall = 1'b0;
        for (int unsigned r = 0; r < NREGS; r++) begin
            logic [1:0]    rel;
            logic [EW-1:0] cur;
            rel    = {1'b0, bus.w_en && bus.w_dstE == IDX_W'(r)}
                   + {1'b0, bus.w_en && bus.w_dstM == IDX_W'(r)};
            res[r] = {1'b0, dst_e == IDX_W'(r)} + {1'b0, dst_m == IDX_W'(r)};
            cur    = EW'(cnt_q[r]);
            if (EW'(rel) > cur) begin
                eff[r] = '0;
                err_d  = 1'b1;
            end else begin
                eff[r] = cur - EW'(rel);
            end
            if ((src_a == IDX_W'(r) || src_b == IDX_W'(r)) && eff[r] != '0)
                stall = 1'b1;
            if (res[r] != 2'd0 && eff[r] + EW'(res[r]) > CMAX)
                stall = 1'b1;
        end
        for (int unsigned r = 0; r < NREGS; r++) begin
            if (bus.d_valid && !stall)
                cnt_d[r] = CNT_W'(eff[r] + EW'(res[r]));
            else
                cnt_d[r] = CNT_W'(eff[r]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                regs_q[r] <= (r == RSP_IDX) ? SP_INIT : '0;
                cnt_q[r]  <= '0;
            end
            err_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign bus.d_srcA  = src_a;
    assign bus.d_srcB  = src_b;
    assign bus.d_dstE  = dst_e;
    assign bus.d_dstM  = dst_m;
    assign bus.d_valA  = (src_a < IDX_W'(NREGS)) ? regs_d[src_a] : '0;
    assign bus.d_valB  = (src_b < IDX_W'(NREGS)) ? regs_d[src_b] : '0;
    assign bus.d_stall = bus.d_valid && stall;
    assign bus.sb_err  = err_q;

endmodule

// File: tb/tb_decode_wb_scoreboard.sv
// Directed scoreboard bench for decode_wb_scoreboard: expectations are queued
// when stimulus is driven and popped against DUT outputs once they settle.
module tb_decode_wb_scoreboard;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decode_wb_scoreboard_if #(.DATA_W(32), .IDX_W(4)) bus ();

    decode_wb_scoreboard #(
        .DATA_W (32),
        .IDX_W  (4),
        .NREGS  (15),
        .RSP_IDX(4),
        .SP_INIT(32'h0000_0200),
        .CNT_W  (2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic expect_v(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        q.push_back(e);
    endtask

    task automatic check_v(input logic [31:0] obs);
        exp_t e;
        vectors++;
        if (q.size() == 0) begin
            miscompares++;
            $error("FAIL sb_empty: observed %h required <none>", obs);
        end else begin
            e = q.pop_front();
            assert (obs === e.val) else begin
                miscompares++;
                $error("FAIL %s: observed %h required %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic idle();
        bus.d_valid = 1'b0;
        bus.d_icode = 4'h0;
        bus.d_rA    = 4'hF;
        bus.d_rB    = 4'hF;
        bus.w_en    = 1'b0;
        bus.w_cnd   = 1'b0;
        bus.w_dstE  = 4'hF;
        bus.w_dstM  = 4'hF;
        bus.w_valE  = '0;
        bus.w_valM  = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // icode 2 routes rA to srcA; d_valid=0 keeps the read side-effect free
    task automatic read_reg(input logic [3:0] r, input logic [31:0] e);
        bus.d_valid = 1'b0;
        bus.d_icode = 4'h2;
        bus.d_rA    = r;
        bus.d_rB    = 4'hF;
        expect_v($sformatf("reg%0d", r), e);
        #1;
        check_v(bus.d_valA);
    endtask

    task automatic wb(input logic cnd, input logic [3:0] de, input logic [31:0] ve,
                      input logic [3:0] dm, input logic [31:0] vm);
        bus.w_en   = 1'b1;
        bus.w_cnd  = cnd;
        bus.w_dstE = de;
        bus.w_valE = ve;
        bus.w_dstM = dm;
        bus.w_valM = vm;
    endtask

    task automatic dec(input logic v, input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb);
        bus.d_valid = v;
        bus.d_icode = ic;
        bus.d_rA    = ra;
        bus.d_rB    = rb;
    endtask

    initial begin
        idle();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wb(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
               4'($urandom_range(0, 15)), $urandom);
            dec(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            tick();
        end

        // Reset edge with live traffic that must be ignored
        rst_n = 1'b0;
        wb(1'b1, 4'h2, 32'hDEAD_0001, 4'h3, 32'hDEAD_0002);
        dec(1'b1, 4'h3, 4'hF, 4'h2);
        tick();
        idle();
        rst_n = 1'b1;
        expect_v("stall_rst", 0);
        expect_v("sberr_rst", 0);
        #1;
        check_v(bus.d_stall);
        check_v(bus.sb_err);
        for (int r = 0; r < 16; r++)
            read_reg(4'(r), (r == 4) ? 32'h200 : 32'h0);

        dec(1'b0, 4'h9, 4'hF, 4'hF);
        expect_v("srcA_push", 4);
        expect_v("srcB_push", 4);
        expect_v("dstE_push", 4);
        expect_v("dstM_push", 15);
        expect_v("valA_push", 32'h200);
        #1;
        check_v(bus.d_srcA);
        check_v(bus.d_srcB);
        check_v(bus.d_dstE);
        check_v(bus.d_dstM);
        check_v(bus.d_valA);

        // RAW on r2 and same-cycle release with bypass
        tick();
        idle();
        dec(1'b1, 4'h3, 4'hF, 4'h2);
        expect_v("irmov_stall", 0);
        expect_v("irmov_dstE", 2);
        #1;
        check_v(bus.d_stall);
        check_v(bus.d_dstE);
        tick();
        dec(1'b1, 4'h6, 4'h2, 4'h3);
        expect_v("raw_stall", 1);
        #1;
        check_v(bus.d_stall);
        wb(1'b1, 4'h2, 32'h1234, 4'hF, 32'h0);
        expect_v("raw_release_stall", 0);
        expect_v("raw_bypass_valA", 32'h1234);
        #1;
        check_v(bus.d_stall);
        check_v(bus.d_valA);
        tick();
        idle();
        read_reg(4'h2, 32'h1234);
        dec(1'b1, 4'h6, 4'h2, 4'hF);
        expect_v("r2_cnt_zero", 0);
        #1;
        check_v(bus.d_stall);
        bus.d_valid = 1'b0;
        tick();
        wb(1'b1, 4'h3, 32'h55, 4'hF, 32'h0);
        tick();
        idle();
        read_reg(4'h3, 32'h55);

        // popq %rsp: both ports on r4, M wins, counter drops by 2
        tick();
        dec(1'b1, 4'hB, 4'h4, 4'hF);
        expect_v("popq_stall", 0);
        expect_v("popq_dstM", 4);
        #1;
        check_v(bus.d_stall);
        check_v(bus.d_dstM);
        tick();
        dec(1'b1, 4'h9, 4'hF, 4'hF);
        expect_v("rsp_busy_stall", 1);
        #1;
        check_v(bus.d_stall);
        wb(1'b1, 4'h4, 32'h208, 4'h4, 32'hABCD);
        expect_v("popq_release_stall", 0);
        expect_v("popq_bypass_valA", 32'hABCD);
        #1;
        check_v(bus.d_stall);
        check_v(bus.d_valA);
        bus.d_valid = 1'b0;
        tick();
        idle();
        read_reg(4'h4, 32'hABCD);
        dec(1'b1, 4'h9, 4'hF, 4'hF);
        expect_v("r4_cnt_zero", 0);
        expect_v("popq_sberr", 0);
        #1;
        check_v(bus.d_stall);
        check_v(bus.sb_err);
        bus.d_valid = 1'b0;

        // cmov not taken: no write, counter still released
        tick();
        dec(1'b1, 4'h2, 4'h1, 4'h5);
        expect_v("cmov_stall", 0);
        #1;
        check_v(bus.d_stall);
        tick();
        dec(1'b1, 4'h6, 4'h5, 4'h0);
        expect_v("r5_reader_stall", 1);
        #1;
        check_v(bus.d_stall);
        wb(1'b0, 4'h5, 32'hFFFF, 4'hF, 32'h0);
        expect_v("cmov_nt_stall", 0);
        expect_v("cmov_nt_valA", 0);
        #1;
        check_v(bus.d_stall);
        check_v(bus.d_valA);
        bus.d_valid = 1'b0;
        tick();
        idle();
        read_reg(4'h5, 32'h0);

        // Saturation on r7
        for (int i = 0; i < 3; i++) begin
            tick();
            idle();
            dec(1'b1, 4'h3, 4'hF, 4'h7);
            expect_v($sformatf("sat_res%0d", i), 0);
            #1;
            check_v(bus.d_stall);
        end
        tick();
        expect_v("sat_stall", 1);
        #1;
        check_v(bus.d_stall);
        tick();
        expect_v("sat_hold", 1);
        #1;
        check_v(bus.d_stall);
        wb(1'b1, 4'h7, 32'h77, 4'hF, 32'h0);
        expect_v("sat_release_stall", 0);
        #1;
        check_v(bus.d_stall);
        tick();
        idle();
        dec(1'b1, 4'h3, 4'hF, 4'h7);
        expect_v("sat_net_sum", 1);
        #1;
        check_v(bus.d_stall);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        expect_v("rst_clears_cnt", 0);
        #1;
        check_v(bus.d_stall);
        bus.d_valid = 1'b0;
        read_reg(4'h2, 32'h0);
        read_reg(4'h4, 32'h200);
        read_reg(4'h7, 32'h0);

        // Release on an idle counter: write lands, error sticks
        tick();
        idle();
        wb(1'b0, 4'hF, 32'h0, 4'h6, 32'h6666);
        expect_v("sberr_pre", 0);
        #1;
        check_v(bus.sb_err);
        tick();
        idle();
        expect_v("sberr_set", 1);
        #1;
        check_v(bus.sb_err);
        read_reg(4'h6, 32'h6666);
        tick();
        tick();
        expect_v("sberr_sticky", 1);
        #1;
        check_v(bus.sb_err);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        expect_v("sberr_rst_clear", 0);
        #1;
        check_v(bus.sb_err);

        if (q.size() != 0) begin
            miscompares += q.size();
            $display("FAIL sb_leftover: observed %0d unchecked required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/decode_wb_scoreboard.md
Name: decode_wb_scoreboard

Overview:
- Parametrised decode/write-back stage for the pipelined Y86 core.
- Derives srcA/srcB/dstE/dstM from icode/rA/rB and reads two operands from a clocked register file.
- Commits write-back results with same-cycle bypass.
- Tracks in-flight destination writes in a per-register pending-count scoreboard and raises a decode stall on RAW hazards or counter saturation.

Parameters:
- DATA_W, 32, register width in bits.
- IDX_W, 4, register index width; index 2**IDX_W-1 is RNONE (never written, reads 0).
- NREGS, 15, implemented registers, indices 0..NREGS-1; NREGS <= 2**IDX_W-1.
- RSP_IDX, 4, stack pointer index.
- SP_INIT, 32'h0000_0200, reset value of register RSP_IDX.
- CNT_W, 2, pending-counter width per register.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- d_valid  in  1  decode-stage instruction present.
- d_icode  in  4  decode icode.
- d_rA  in  IDX_W  decode rA field.
- d_rB  in  IDX_W  decode rB field.
- d_srcA, d_srcB, d_dstE, d_dstM  out  IDX_W  decoded indices, combinational.
- d_valA, d_valB  out  DATA_W  operand values, combinational with bypass.
- d_stall  out  1  decode must hold; no reservation made.
- w_en  in  1  write-back instruction retires this cycle.
- w_cnd  in  1  condition flag; gates the E-port write only.
- w_dstE, w_dstM  in  IDX_W  write-back destinations.
- w_valE, w_valM  in  DATA_W  write-back data.
- sb_err  out  1  sticky: release seen on a zero counter.

Behaviour:
- Reset is synchronous, sampled on the clk rising edge while rst_n=0.
  - All registers are set to 0, except RSP_IDX, which is set to SP_INIT.
  - All counters are set to 0; sb_err is cleared to 0.
  - w_en and d_valid are ignored while rst_n=0.
- Decode map (icode hex):
  - srcA = rA for 2,4,6,A; RSP for 9,B; else RNONE.
  - srcB = rB for 4,5,6; RSP for 8,9,A,B; else RNONE.
  - dstE = rB for 2,3,6; RSP for 8,9,A,B; else RNONE.
  - dstM = rA for 5,B; else RNONE.
  - icode 2 (cmov) always reserves rB; a not-taken move is resolved at write-back.
- Read:
  - valX = regs[srcX], or 0 if srcX=RNONE or srcX>=NREGS.
  - Bypass, write-first:
    - If w_en and w_dstM==srcX, then valX = w_valM.
    - Else if w_en and w_cnd and w_dstE==srcX, then valX = w_valE.
    - M has priority over E.
- Write, at the clock edge when w_en=1:
  - E port writes w_valE to w_dstE only if w_cnd=1.
  - M port writes w_valM to w_dstM.
  - If both ports target the same register, M wins (popq %rsp semantics).
  - Writes to RNONE or to indices >= NREGS are dropped.
- Release:
  - w_en decrements cnt[w_dstE] and cnt[w_dstM], each non-RNONE port by 1.
  - This happens regardless of w_cnd.
  - Same register on both ports decrements by 2.
  - A decrement below 0 clamps the counter at 0 and sets sb_err, which stays set until reset.
- Hazard: define eff[r] = cnt[r] minus the same-cycle release to r.
  - d_stall = d_valid AND any of:
    - eff[srcA] != 0;
    - eff[srcB] != 0;
    - eff[dstE] + inc_E > 2**CNT_W-1;
    - eff[dstM] + inc_M > 2**CNT_W-1.
  - inc counts how many dst ports name that register. RNONE never stalls.
  - d_stall is combinational.
- Reserve: when d_valid=1 and d_stall=0, each non-RNONE dst increments its counter.
  - Same-cycle reserve and release on one register nets to the arithmetic sum.
- Latency:
  - Reads are zero-cycle.
  - A written value is visible in regs at the next cycle and via bypass in the same cycle.
  - A stall clears in the same cycle as the releasing write-back.

Test Plan:
- Reset with random prior state → regs[4]=0x200, regs[0..3,5..14]=0, d_stall=0, sb_err=0; icode 9 decodes srcA=srcB=dstE=4 and valA=0x200.
- Decode irmovq (icode 3, rB=2), reserving r2; next cycle decode OPq (icode 6, rA=2, rB=3) → d_stall=1. Then w_en=1, w_dstE=2, w_valE=0x1234, w_cnd=1 → same cycle d_stall=0, d_valA=0x1234; next cycle regs[2]=0x1234.
- popq %rsp writeback: w_dstE=4, w_valE=0x208, w_dstM=4, w_valM=0xABCD → regs[4]=0xABCD; counter for r4 decremented by 2.
- Cmov not taken: w_en=1, w_cnd=0, w_dstE=5, w_valE=0xFFFF → regs[5] unchanged, cnt[5] decremented, d_stall on r5 readers clears.
- Saturation: three irmovq to r7 with no write-back → cnt[7]=3; a fourth issues d_stall=1 and cnt stays 3. Assert rst_n=0 mid-sequence → next cycle all counters 0, d_stall=0.
- w_en=1 with w_dstM=6 while cnt[6]=0 → regs[6] written, sb_err=1 and stays 1 until reset.
